// File: rtl/hilo_mdu_ctrl.sv
// HI/LO special-register sequencer: iterative MULTU/DIVU (one bit per cycle),
// MTHI/MTLO writes, MFHI/MFLO read enables, and pipeline stall generation.
module hilo_mdu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             op_ready,
    output logic             stall,
    output logic             busy,
    output logic             div_zero,
    output logic             hi_rr,
    output logic             lo_rr,
    output logic             hi_rw,
    output logic             lo_rw,
    output logic [WIDTH-1:0] hi_wdata,
    output logic [WIDTH-1:0] lo_wdata
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MUL    = 2'd1;
    localparam logic [1:0] S_DIV    = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    localparam logic [2:0] OP_MULTU = 3'd0;
    localparam logic [2:0] OP_DIVU  = 3'd1;
    localparam logic [2:0] OP_MTHI  = 3'd2;
    localparam logic [2:0] OP_MTLO  = 3'd3;
    localparam logic [2:0] OP_MFHI  = 3'd4;
    localparam logic [2:0] OP_MFLO  = 3'd5;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_acc_q, hi_acc_d;
    logic [WIDTH-1:0] lo_acc_q, lo_acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_wdata_q, hi_wdata_d;
    logic [WIDTH-1:0] lo_wdata_q, lo_wdata_d;
    logic             hi_rw_q, hi_rw_d;
    logic             lo_rw_q, lo_rw_d;
    logic             div_zero_q, div_zero_d;

    logic             accept;
    logic             last_iter;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;

    assign op_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign accept    = op_valid && op_ready && (op <= OP_MTLO);
    assign stall     = op_valid && !op_ready && (op <= OP_MFLO);
    assign hi_rr     = op_valid && (op == OP_MFHI) && op_ready;
    assign lo_rr     = op_valid && (op == OP_MFLO) && op_ready;

    assign hi_rw     = hi_rw_q;
    assign lo_rw     = lo_rw_q;
    assign hi_wdata  = hi_wdata_q;
    assign lo_wdata  = lo_wdata_q;
    assign div_zero  = div_zero_q;

    // Multiply: hi_acc holds the running upper half, lo_acc the multiplier
    // shifting out LSB-first while product bits shift in from the top.
    assign add_sum   = {1'b0, hi_acc_q} + {1'b0, b_q};
    // Divide: hi_acc is the partial remainder, lo_acc the dividend shifting
    // out MSB-first while quotient bits shift in at the bottom.
    assign div_shift = {hi_acc_q, lo_acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
    // remainder < divisor keeps the shifted value below 2*divisor, so a
    // successful subtract always clears the top bit and a borrow always sets it
    assign div_ge    = !div_diff[WIDTH];
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_acc_d   = hi_acc_q;
        lo_acc_d   = lo_acc_q;
        b_d        = b_q;
        hi_wdata_d = hi_wdata_q;
        lo_wdata_d = lo_wdata_q;
        hi_rw_d    = 1'b0;
        lo_rw_d    = 1'b0;
        div_zero_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULTU: begin
                            hi_acc_d = '0;
                            lo_acc_d = op_b;
                            b_d      = op_a;
                            cnt_d    = '0;
                            state_d  = S_MUL;
                        end
                        OP_DIVU: begin
                            if (op_b == '0) begin
                                hi_wdata_d = op_a;
                                lo_wdata_d = '1;
                                hi_rw_d    = 1'b1;
                                lo_rw_d    = 1'b1;
                                div_zero_d = 1'b1;
                                state_d    = S_COMMIT;
                            end else begin
                                hi_acc_d = '0;
                                lo_acc_d = op_a;
                                b_d      = op_b;
                                cnt_d    = '0;
                                state_d  = S_DIV;
                            end
                        end
                        OP_MTHI: begin
                            hi_wdata_d = op_a;
                            hi_rw_d    = 1'b1;
                            state_d    = S_COMMIT;
                        end
                        OP_MTLO: begin
                            lo_wdata_d = op_a;
                            lo_rw_d    = 1'b1;
                            state_d    = S_COMMIT;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (lo_acc_q[0]) begin
                    {hi_acc_d, lo_acc_d} = {add_sum, lo_acc_q[WIDTH-1:1]};
                end else begin
                    {hi_acc_d, lo_acc_d} = {1'b0, hi_acc_q, lo_acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    hi_wdata_d = hi_acc_d;
                    lo_wdata_d = lo_acc_d;
                    hi_rw_d    = 1'b1;
                    lo_rw_d    = 1'b1;
                    state_d    = S_COMMIT;
                end
            end
            S_DIV: begin
                hi_acc_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                lo_acc_d = {lo_acc_q[WIDTH-2:0], div_ge};
                cnt_d    = cnt_q + CW'(1);
                if (last_iter) begin
                    hi_wdata_d = hi_acc_d;
                    lo_wdata_d = lo_acc_d;
                    hi_rw_d    = 1'b1;
                    lo_rw_d    = 1'b1;
                    state_d    = S_COMMIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hi_acc_q   <= '0;
            lo_acc_q   <= '0;
            b_q        <= '0;
            hi_wdata_q <= '0;
            lo_wdata_q <= '0;
            hi_rw_q    <= 1'b0;
            lo_rw_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_acc_q   <= hi_acc_d;
            lo_acc_q   <= lo_acc_d;
            b_q        <= b_d;
            hi_wdata_q <= hi_wdata_d;
            lo_wdata_q <= lo_wdata_d;
            hi_rw_q    <= hi_rw_d;
            lo_rw_q    <= lo_rw_d;
            div_zero_q <= div_zero_d;
        end
    end
endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Self-checking bench for hilo_mdu_ctrl: random and directed MULTU/DIVU/MT/MF
// traffic compared against plain-arithmetic expectations.
module tb_hilo_mdu_ctrl;
    localparam int W = 32;
    localparam int ITER_LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         op_valid;
    logic [2:0]   op;
    logic [W-1:0] op_a, op_b;
    logic         op_ready, stall, busy, div_zero;
    logic         hi_rr, lo_rr, hi_rw, lo_rw;
    logic [W-1:0] hi_wdata, lo_wdata;

    int checks = 0;
    int errors = 0;

    // Architectural HI/LO registers, capturing on the negedge of COMMIT.
    logic [W-1:0] hi_reg = '0, lo_reg = '0;

    hilo_mdu_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .op_a(op_a), .op_b(op_b),
        .op_ready(op_ready), .stall(stall), .busy(busy), .div_zero(div_zero),
        .hi_rr(hi_rr), .lo_rr(lo_rr), .hi_rw(hi_rw), .lo_rw(lo_rw),
        .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (hi_rw) hi_reg <= hi_wdata;
        if (lo_rw) lo_reg <= lo_wdata;
    end

    // Reference results from plain arithmetic.
    task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic ehrw, output logic elrw, output logic edz,
                         output logic [W-1:0] ehi, output logic [W-1:0] elo);
        logic [2*W-1:0] p;
        ehi = 'x; elo = 'x; edz = 1'b0; ehrw = 1'b1; elrw = 1'b1; lat = ITER_LAT;
        case (o)
            3'd0: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; ehi = p[2*W-1:W]; elo = p[W-1:0]; end
            3'd1: begin
                if (b == 0) begin ehi = a; elo = '1; edz = 1'b1; lat = 1; end
                else begin ehi = a % b; elo = a / b; end
            end
            3'd2: begin ehi = a; elrw = 1'b0; lat = 1; end
            default: begin elo = a; ehrw = 1'b0; lat = 1; end
        endcase
    endtask

    // Presents one op at the next negedge and returns at the negedge of COMMIT.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic rdy_before, output int cyc, output logic hrw, output logic lrw,
                         output logic dz, output logic [W-1:0] hw, output logic [W-1:0] lw);
        @(negedge clk);
        rdy_before = op_ready;
        op_valid = 1'b1; op = o; op_a = a; op_b = b;
        @(negedge clk);
        op_valid = 1'b0; op = 3'($urandom_range(0, 7)); op_a = $urandom; op_b = $urandom;
        cyc = 1;
        while (!(hi_rw || lo_rw) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) cyc = -1;
        hrw = hi_rw; lrw = lo_rw; dz = div_zero; hw = hi_wdata; lw = lo_wdata;
    endtask

    task automatic run_checked(input string tag, input logic [2:0] o,
                               input logic [W-1:0] a, input logic [W-1:0] b);
        logic rdy, hrw, lrw, dz, ehrw, elrw, edz;
        logic [W-1:0] hw, lw, ehi, elo;
        int cyc, lat;
        model(o, a, b, lat, ehrw, elrw, edz, ehi, elo);
        issue(o, a, b, rdy, cyc, hrw, lrw, dz, hw, lw);
        checks++;
        if (rdy !== 1'b1 || cyc != lat || hrw !== ehrw || lrw !== elrw || dz !== edz) begin
            errors++;
            $display("FAIL %s op=%0d a=%h b=%h: ready=%b commit_cycle=%0d rw=%b%b dz=%b, expected ready=1 commit_cycle=%0d rw=%b%b dz=%b",
                     tag, o, a, b, rdy, cyc, hrw, lrw, dz, lat, ehrw, elrw, edz);
        end
        checks++;
        if ((ehrw && hw !== ehi) || (elrw && lw !== elo)) begin
            errors++;
            $display("FAIL %s_data op=%0d a=%h b=%h: hi=%h lo=%h, expected hi=%h lo=%h",
                     tag, o, a, b, hw, lw, ehi, elo);
        end
        $display("%s op=%0d a=%h b=%h -> commit@%0d hi=%h lo=%h dz=%b", tag, o, a, b, cyc, hw, lw, dz);
    endtask

    task automatic test_reset();
        rst = 1'b1; op_valid = 1'b0; op = '0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({op_ready, busy, stall, div_zero, hi_rr, lo_rr, hi_rw, lo_rw} !== 8'b1000_0000
            || hi_wdata !== '0 || lo_wdata !== '0) begin
            errors++;
            $display("FAIL reset_state: rdy/busy/stall/dz/rr/rw=%b%b%b%b%b%b%b%b wdata=%h/%h, expected 10000000 and 0/0",
                     op_ready, busy, stall, div_zero, hi_rr, lo_rr, hi_rw, lo_rw, hi_wdata, lo_wdata);
        end
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_multu();
        run_checked("multu_7x6", 3'd0, 32'd7, 32'd6);
        run_checked("multu_max", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_checked("multu_zero", 3'd0, 32'h0, $urandom);
        for (int i = 0; i < 6; i++) run_checked("multu_rand", 3'd0, $urandom, $urandom);
    endtask

    task automatic test_divu();
        run_checked("divu_100_7", 3'd1, 32'd100, 32'd7);
        run_checked("divu_by0", 3'd1, 32'd5, 32'd0);
        run_checked("divu_small_big", 3'd1, 32'd3, 32'hFFFF_FFFF);
        run_checked("divu_max_1", 3'd1, 32'hFFFF_FFFF, 32'd1);
        for (int i = 0; i < 6; i++)
            run_checked("divu_rand", 3'd1, $urandom, 32'($urandom_range(1, 32'hFFFF)) << $urandom_range(0, 16));
    endtask

    task automatic test_mt_mf();
        logic [W-1:0] v;
        @(negedge clk);
        op_valid = 1'b1; op = 3'd2; op_a = 32'h1234;
        @(negedge clk);
        op = 3'd4; op_a = $urandom;
        #1;
        checks++;
        if (stall !== 1'b1 || hi_rw !== 1'b1 || lo_rw !== 1'b0 || hi_rr !== 1'b0 || hi_wdata !== 32'h1234) begin
            errors++;
            $display("FAIL mthi_commit: stall=%b hi_rw=%b lo_rw=%b hi_rr=%b hi_wdata=%h, expected 1 1 0 0 00001234",
                     stall, hi_rw, lo_rw, hi_rr, hi_wdata);
        end
        @(negedge clk);
        #1;
        checks++;
        if (hi_rr !== 1'b1 || stall !== 1'b0 || hi_reg !== 32'h1234 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mfhi_after_mthi: hi_rr=%b stall=%b hi_reg=%h busy=%b, expected 1 0 00001234 0",
                     hi_rr, stall, hi_reg, busy);
        end
        $display("mthi 00001234 then mfhi -> hi_rr=%b hi_reg=%h", hi_rr, hi_reg);
        op_valid = 1'b0;
        v = $urandom;
        run_checked("mtlo", 3'd3, v, $urandom);
        @(negedge clk);
        op_valid = 1'b1; op = 3'd5;
        #1;
        checks++;
        if (lo_rr !== 1'b1 || hi_rr !== 1'b0 || stall !== 1'b0 || lo_reg !== v) begin
            errors++;
            $display("FAIL mflo_after_mtlo: lo_rr=%b hi_rr=%b stall=%b lo_reg=%h, expected 1 0 0 %h",
                     lo_rr, hi_rr, stall, lo_reg, v);
        end
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic test_mf_busy();
        int bad = 0;
        @(negedge clk);
        op_valid = 1'b1; op = 3'd0; op_a = $urandom; op_b = $urandom;
        @(negedge clk);
        op = 3'd5;
        for (int k = 1; k <= ITER_LAT; k++) begin
            #1;
            if (stall !== 1'b1 || lo_rr !== 1'b0 || op_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        #1;
        checks++;
        if (bad != 0 || lo_rr !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL mflo_busy: bad_busy_cycles=%0d lo_rr_at_idle=%b stall_at_idle=%b, expected 0 1 0",
                     bad, lo_rr, stall);
        end
        op_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (lo_rr !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mflo_single: lo_rr=%b busy=%b after release, expected 0 0", lo_rr, busy);
        end
        $display("mflo held during multu -> stalled %0d cycles, bad=%0d", ITER_LAT, bad);
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        logic [W-1:0] v;
        @(negedge clk);
        op_valid = 1'b1; op = 3'd0; op_a = $urandom; op_b = $urandom;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || op_ready !== 1'b1 || hi_rw !== 1'b0 || lo_rw !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b op_ready=%b rw=%b%b, expected 0 1 00", busy, op_ready, hi_rw, lo_rw);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (hi_rw || lo_rw || busy) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_abort: %0d cycles with rw/busy after reset, expected 0", pulses);
        end
        $display("reset at multu iteration 10 -> activity_cycles=%0d", pulses);
        v = $urandom;
        run_checked("mtlo_after_rst", 3'd3, v, 32'h0);
    endtask

    task automatic test_ignored();
        int cyc = 0;
        for (int o = 6; o <= 7; o++) begin
            @(negedge clk);
            op_valid = 1'b1; op = 3'(o); op_a = $urandom; op_b = $urandom;
            #1;
            checks++;
            if ({stall, hi_rr, lo_rr} !== 3'b000) begin
                errors++;
                $display("FAIL ignored_idle op=%0d: stall/hi_rr/lo_rr=%b, expected 000", o, {stall, hi_rr, lo_rr});
            end
            @(negedge clk);
            checks++;
            if ({busy, hi_rw, lo_rw} !== 3'b000) begin
                errors++;
                $display("FAIL ignored_state op=%0d: busy/hi_rw/lo_rw=%b, expected 000", o, {busy, hi_rw, lo_rw});
            end
            $display("ignored op=%0d -> busy=%b stall=%b", o, busy, stall);
        end
        op = 3'd0; op_a = 32'd3; op_b = 32'd4;
        @(negedge clk);
        op = 3'd7;
        #1;
        checks++;
        if (stall !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ignored_busy: stall=%b busy=%b, expected 0 1", stall, busy);
        end
        op_valid = 1'b0;
        while (!lo_rw && cyc < 100) begin @(negedge clk); cyc++; end
        checks++;
        if (cyc >= 100 || lo_wdata !== 32'd12) begin
            errors++;
            $display("FAIL ignored_busy_commit: waited=%0d lo_wdata=%h, expected commit with 0000000c", cyc, lo_wdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ehi, elo, a, b;
        logic [2:0] o;
        logic rdy, hrw, lrw, dz, ehrw, elrw, edz;
        logic [W-1:0] hw, lw, mhi, mlo;
        int cyc, lat;
        ehi = hi_reg; elo = lo_reg;
        for (int i = 0; i < 10; i++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            model(o, a, b, lat, ehrw, elrw, edz, mhi, mlo);
            if (ehrw) ehi = mhi;
            if (elrw) elo = mlo;
            issue(o, a, b, rdy, cyc, hrw, lrw, dz, hw, lw);
            checks++;
            if (rdy !== 1'b1 || cyc != lat || hrw !== ehrw || lrw !== elrw || dz !== edz
                || (ehrw && hw !== mhi) || (elrw && lw !== mlo)) begin
                errors++;
                $display("FAIL b2b_%0d op=%0d a=%h b=%h: ready=%b cyc=%0d rw=%b%b dz=%b hi=%h lo=%h, expected 1 %0d %b%b %b %h %h",
                         i, o, a, b, rdy, cyc, hrw, lrw, dz, hw, lw, lat, ehrw, elrw, edz, mhi, mlo);
            end
            $display("b2b %0d op=%0d a=%h b=%h -> commit@%0d hi=%h lo=%h", i, o, a, b, cyc, hw, lw);
        end
        @(negedge clk);
        checks++;
        if (hi_reg !== ehi || lo_reg !== elo) begin
            errors++;
            $display("FAIL b2b_regs: hi=%h lo=%h, expected hi=%h lo=%h", hi_reg, lo_reg, ehi, elo);
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_divu();
        test_mt_mf();
        test_mf_busy();
        test_reset_mid();
        test_ignored();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
